mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single external SPI memory controller between the instruction-fetch unit (port A, read-only) and the load/store unit (port B, read/write). It latches the granted request, drives the controller's level-held start/done handshake, and returns read data and completion on the owning port. It enforces a start-low gap between transactions so the controller always returns to its start state. It also bounds every transaction with a timeout.

## Interface
- TIMEOUT_CYCLES, 4095, max cycles in BUSY before forced completion; 0 disables the timeout
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- a_req  in  1  fetch request, level; held high until a_done
- a_addr  in  32  fetch address; bits [31:24] select the chip, [23:0] the byte address
- a_num_bytes  in  3  bytes to read
- a_done  out  1  fetch complete; high while a_req is held
- a_err  out  1  qualifies a_done: transaction timed out
- a_rdata  out  32  fetched data, right-aligned
- b_req, b_addr, b_num_bytes, b_done, b_err, b_rdata  same meaning for the data port
- b_is_write  in  1  1 = write
- b_wdata  in  32  write value
- mem_start_request  out  1  to controller start_request
- mem_target_address  out  32  latched address
- mem_num_bytes  out  3  latched, clamped byte count
- mem_is_write  out  1  latched; always 0 for port A
- mem_write_value  out  32  latched; 0 for port A
- mem_request_done  in  1  from controller
- mem_target_data  in  32  from controller; valid while mem_request_done=1

## Operation
- States: IDLE, BUSY, DONE. Registers: owner (A/B), last_owner, timeout counter, err, latched request fields, a_rdata, b_rdata.
- IDLE:
  - If any req is high, grant it, latch its fields and set mem_start_request=1. Go to BUSY.
  - On a tie, grant the port that is not last_owner (round-robin).
- BUSY:
  - mem_start_request=1 and latched fields are held constant.
  - On mem_request_done=1: capture mem_target_data into the owner's rdata, clear err, drop mem_start_request, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES first: set err, leave rdata unchanged, drop mem_start_request, go to DONE.
- DONE:
  - x_done = (owner==x) && x_req; x_err = x_done && err.
  - When the owner's req is low, go to IDLE, set last_owner=owner.
- Abort: if the owner drops req during BUSY, the transaction still runs to mem_request_done or timeout. rdata is captured but done never asserts, because req is already low. DONE then exits on the next cycle.
- Byte count: num_bytes values 5–7 are clamped to 4; values 0–4 pass through unchanged.
- Port A always drives mem_is_write=0 and mem_write_value=0.
- Request fields are sampled only at grant. Changes made while BUSY are ignored.
- Non-owner done and err outputs are always 0.

## Timing
- Reset values:
  - state=IDLE, last_owner=A (so B wins the first tie).
  - mem_start_request=0 and all mem_* fields=0.
  - a_done=b_done=a_err=b_err=0, a_rdata=b_rdata=0, counter=0.
- Grant latency: req first seen high at edge n → mem_start_request and fields valid after edge n.
- Completion: mem_request_done seen at edge m → x_done, x_rdata and mem_start_request=0 valid after edge m.
- Release: x_req low at edge k → x_done=0 and IDLE after edge k. The earliest next mem_start_request is after edge k+1.
- Start-low gap: mem_start_request is low for at least 2 cycles between transactions.
- Timeout: the counter increments every cycle in BUSY, is cleared on grant, and fires when it equals TIMEOUT_CYCLES; it saturates.
- Back-to-back: with both reqs held continuously, grants alternate A/B/A/… with no starvation.

## Structure
- Shared package holds:
  - state encodings IDLE/BUSY/DONE
  - owner encodings PORT_A/PORT_B
  - MEM_MAX_BYTES=4
  - the start-low gap constant for the controller handshake
- The block is a single module with no required sub-module. The round-robin pick is a small combinational function in the package.

## Test plan
- Single fetch: a_req=1, a_addr=0x00000100, a_num_bytes=4; controller model answers 0xDEADBEEF after 60 cycles → mem_target_address=0x00000100, mem_is_write=0, a_done=1, a_rdata=0xDEADBEEF, b_done=0.
- Simultaneous after reset: a_req and b_req rise on the same edge → B is granted first. A is granted once B drops req, and start is low for ≥2 cycles in between.
- Write: b_req, b_is_write=1, b_addr=0x01000010, b_wdata=0x12345678, b_num_bytes=7 → mem_num_bytes=4, mem_write_value=0x12345678, b_done after mem_request_done.
- Timeout: TIMEOUT_CYCLES=16, controller never answers → b_done=b_err=1 after 16 BUSY cycles, b_rdata unchanged, mem_start_request=0.
- Abort: a_req drops mid-BUSY → start stays high until mem_request_done, a_done never asserts, a_rdata updated, and the next pending b_req is granted afterwards.
- Reset mid-BUSY: rst_n=0 for 1 cycle → all outputs at reset values on the next cycle, and state is IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the two-port SPI memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Port ownership
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Largest transfer the controller accepts in one transaction
  localparam logic [2:0] MEM_MAX_BYTES = 3'd4;

  // Minimum cycles start_request stays low between transactions, so the
  // controller always falls back to its start state.
  localparam int START_LOW_GAP = 2;

  // Request fields latched at grant and held for the whole transaction
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  num_bytes;
    logic        is_write;
    logic [31:0] wdata;
  } mem_req_t;

  // Round-robin pick: on a tie the port that did not go last wins.
  function automatic logic rr_pick(input logic a_req, input logic b_req,
                                   input logic last_owner);
    if (a_req && b_req) return ~last_owner;
    return b_req ? PORT_B : PORT_A;
  endfunction

  // Oversized byte counts are trimmed to what the controller can move.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
    return (n > MEM_MAX_BYTES) ? MEM_MAX_BYTES : n;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one SPI memory controller between the fetch port (A, read-only)
// and the load/store port (B). Latches the granted request, holds the
// level-based start/done handshake and bounds each transaction by a timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  // port A: instruction fetch
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [2:0]  a_num_bytes,
  output logic        a_done,
  output logic        a_err,
  output logic [31:0] a_rdata,
  // port B: load/store
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [2:0]  b_num_bytes,
  input  logic        b_is_write,
  input  logic [31:0] b_wdata,
  output logic        b_done,
  output logic        b_err,
  output logic [31:0] b_rdata,
  // controller side
  output logic        mem_start_request,
  output logic [31:0] mem_target_address,
  output logic [2:0]  mem_num_bytes,
  output logic        mem_is_write,
  output logic [31:0] mem_write_value,
  input  logic        mem_request_done,
  input  logic [31:0] mem_target_data
);

  // Wide enough to hold TIMEOUT_CYCLES and still saturate above it.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  logic [1:0]    state;
  logic          owner;
  logic          last_owner;
  logic          err;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          grant_port;
  logic          owner_req;
  mem_req_t      grant_req;
  mem_req_t      lat_q;

  // Grant selection, saturating timeout count and owner's live request
  always_comb begin
    grant_port = rr_pick(a_req, b_req, last_owner);
    if (grant_port == PORT_B)
      grant_req = '{addr: b_addr, num_bytes: clamp_bytes(b_num_bytes),
                    is_write: b_is_write, wdata: b_wdata};
    else
      grant_req = '{addr: a_addr, num_bytes: clamp_bytes(a_num_bytes),
                    is_write: 1'b0, wdata: 32'd0};
    cnt_inc     = (&cnt) ? cnt : cnt + CW'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));
    owner_req   = (owner == PORT_B) ? b_req : a_req;
  end

  // Arbiter FSM: grant, hold start until done/timeout, wait for release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      owner             <= PORT_A;
      last_owner        <= PORT_A;
      err               <= 1'b0;
      cnt               <= '0;
      lat_q             <= '0;
      mem_start_request <= 1'b0;
      a_rdata           <= 32'd0;
      b_rdata           <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_req || b_req) begin
            owner             <= grant_port;
            lat_q             <= grant_req;
            cnt               <= '0;
            err               <= 1'b0;
            mem_start_request <= 1'b1;
            state             <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Completion wins over a timeout landing on the same cycle; data
          // is captured even if the owner already dropped its request.
          if (mem_request_done) begin
            if (owner == PORT_B) b_rdata <= mem_target_data;
            else                 a_rdata <= mem_target_data;
            err               <= 1'b0;
            mem_start_request <= 1'b0;
            state             <= ST_DONE;
          end else begin
            cnt <= cnt_inc;
            if (timeout_hit) begin
              err               <= 1'b1;
              mem_start_request <= 1'b0;
              state             <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Leaving DONE only after release guarantees start stays low for
          // at least START_LOW_GAP cycles before the next grant.
          if (!owner_req) begin
            last_owner <= owner;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_target_address = lat_q.addr;
  assign mem_num_bytes      = lat_q.num_bytes;
  assign mem_is_write       = lat_q.is_write;
  assign mem_write_value    = lat_q.wdata;

  // Completion is visible only to the owner and only while it still asks.
  assign a_done = (state == ST_DONE) && (owner == PORT_A) && a_req;
  assign b_done = (state == ST_DONE) && (owner == PORT_B) && b_req;
  assign a_err  = a_done && err;
  assign b_err  = b_done && err;

endmodule
